// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for the boot image loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int BUF_W          = 8 * (BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// rtl/imem_loader_byte_to_word_packer.sv - little-endian byte to 32-bit word assembler
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [LANE_W-1:0] byte_lane;
    logic [BUF_W-1:0]  shift_buf;

    // Each new byte enters at the top, so after three bytes the first one sits in bits [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_lane <= '0;
            shift_buf <= '0;
        end else if (byte_en) begin
            byte_lane <= byte_lane + LANE_W'(1);
            shift_buf <= {byte_data, shift_buf[BUF_W-1:8]};
        end
    end

    assign word_valid = byte_en && (byte_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, shift_buf};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte stream into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDX_W  = $clog2(IMEM_DEPTH) + 1;
    localparam int HCNT_W = $clog2(HDR_BYTES);

    state_t             state;
    state_t             state_next;
    logic [HCNT_W-1:0]  hdr_cnt;
    logic [CNT_W-1:0]   hdr_shift;
    logic [CNT_W-1:0]   hdr_full;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   n_words;
    logic [7:0]         csum;
    logic               in_load;
    logic               accept;
    logic               hdr_last;
    logic               oversize;
    logic               last_word;
    logic               word_valid;
    logic [31:0]        word;

    assign in_load    = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign byte_ready = in_load && rst;
    assign accept     = byte_valid && byte_ready;

    assign hdr_full   = {byte_data, hdr_shift[CNT_W-1:8]};
    assign hdr_last   = (hdr_cnt == HCNT_W'(HDR_BYTES - 1));
    assign oversize   = (hdr_full > CNT_W'(IMEM_DEPTH));
    // Once the header is complete its low bits hold N, already bounded by IMEM_DEPTH.
    assign n_words    = hdr_shift[IDX_W-1:0];
    assign last_word  = ((word_idx + IDX_W'(1)) == n_words);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (accept && (state == ST_DATA)),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (state)
            ST_HDR: begin
                if (accept && hdr_last) begin
                    if (oversize) begin
                        state_next = ST_ERR;
                    end else if (hdr_full == '0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_next = (byte_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: load_done = 1'b1;
            ST_ERR:  load_err  = 1'b1;
            default: state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_cnt    <= '0;
            hdr_shift  <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
        end else begin
            imem_we  <= word_valid;
            core_rst <= (state == ST_DONE);
            if (accept && (state == ST_HDR)) begin
                hdr_shift <= hdr_full;
                hdr_cnt   <= hdr_cnt + HCNT_W'(1);
            end
            if (accept && (state == ST_DATA)) begin
                csum <= csum ^ byte_data;
            end
            if (word_valid) begin
                imem_addr  <= 32'({word_idx, 2'b00});
                imem_wdata <= word;
                word_idx   <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule
